safelock_state_decoder: RTL and testbench
=========================================

Name:
safelock_state_decoder

Overview:
- Registered 7-segment glyph decoder for the Smart Safelock controller.
- Converts the 3-bit lock FSM state code into a single-digit 7-segment pattern for the board display.
- Sits between the lock control FSM (which drives the state code) and the seven-segment display pins.
- Adds blinking of the ERROR glyph and a segment-polarity option.

Parameters:
- ACTIVE_LOW, 1, 1 = segment driven 0 when lit (common-anode board); 0 = segment driven 1 when lit.
- BLINK_CYCLES, 50_000_000, clock cycles per blink half-period in the ERROR state; legal range ≥ 1.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst_n  input  1  asynchronous reset, active-low.
- i_state  input  3  lock FSM state code, 0..5 defined, 6..7 invalid.
- o_7seg  output  7  segment drive; bit0 = a, bit1 = b, … bit6 = g; polarity per ACTIVE_LOW; registered.

Behaviour:
- Glyph table, active-high form with bit0 = a (bit = 1 means segment lit):
  - 0 IDLE: "-" = 7'b1000000
  - 1 DIGIT1: "1" = 7'b0000110
  - 2 DIGIT2: "2" = 7'b1011011
  - 3 DIGIT3: "3" = 7'b1001111
  - 4 OPEN: "O" = 7'b0111111
  - 5 ERROR: "E" = 7'b1111001
  - 6, 7: blank = 7'b0000000
- Output polarity:
  - ACTIVE_LOW = 1: o_7seg = bitwise inverse of the glyph, e.g. "-" = 7'b0111111, "E" = 7'b0000110, blank = 7'b1111111.
  - ACTIVE_LOW = 0: o_7seg = glyph unchanged.
- Latency and update:
  - i_state is sampled on each rising i_clk edge.
  - o_7seg shows the corresponding pattern after that edge: 1-cycle latency, no combinational path from input to output.
- Reset:
  - i_rst_n low forces o_7seg to blank immediately (all segments off: 7'h7F when ACTIVE_LOW = 1, 7'h00 otherwise).
  - Reset also clears the blink counter and the blink phase.
  - First decode occurs on the first rising edge after i_rst_n is released.
- ERROR blink:
  - Internal counter of width clog2(BLINK_CYCLES) plus a phase bit.
  - Entering state 5 from any other state (detected on the registered previous state) clears the counter and sets phase = show.
  - So the "E" glyph appears on the first cycle in ERROR.
  - While state stays 5: counter increments each cycle; on reaching BLINK_CYCLES-1 it wraps to 0 and the phase toggles.
  - Output = "E" in the show phase, blank in the hide phase.
  - Each half-period lasts exactly BLINK_CYCLES cycles.
  - Leaving state 5 stops the counter and resets it to 0; the output follows the new state's glyph on the next edge.
- BLINK_CYCLES = 1: phase toggles every cycle.
- Invalid codes 6/7 give blank and never disturb the blink logic.
- Reset asserted mid-blink: output blanks asynchronously; after release, ERROR restarts with the show phase.
- Input changing every cycle: every code is reflected one cycle later; there is no filtering.

Test Plan:
- Reset: hold i_rst_n = 0 and toggle the clock → o_7seg = 7'h7F; deassert reset with i_state = 0 → next edge o_7seg = 7'b0111111.
- Sweep: ACTIVE_LOW = 1, drive i_state 0..4, one value per clock → o_7seg lags by one cycle: 0111111, 1111001, 0100100, 0110000, 1000000.
- Invalid codes: i_state = 6 then 7 → o_7seg = 7'b1111111 both cycles.
- ERROR blink: BLINK_CYCLES = 3, i_state = 5 held → o_7seg = 0000110 ×3 cycles, 1111111 ×3, 0000110 ×3; leave to state 1 mid-hide → next edge 1111001; re-enter 5 → "E" immediately.
- Polarity: ACTIVE_LOW = 0, i_state = 4 → o_7seg = 7'b0111111; during reset → 7'h00.
- Async reset mid-operation: assert i_rst_n = 0 between clock edges while in state 3 → o_7seg goes blank without waiting for a clock edge.

Source files
------------

// File: rtl/safelock_state_decoder.sv
// Registered 7-segment glyph decoder for the Smart Safelock lock-state display.
// Blinks the ERROR glyph with a programmable half-period and supports either segment polarity.
module safelock_state_decoder #(
    parameter int          ACTIVE_LOW   = 1,
    parameter int unsigned BLINK_CYCLES = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_state,
    output logic [6:0] o_7seg
);

    // A one-cycle half-period still needs a one-bit counter so the compare below stays legal.
    localparam int unsigned CNT_W = (BLINK_CYCLES > 32'd1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 32'd1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DIGIT1 = 3'd1;
    localparam logic [2:0] ST_DIGIT2 = 3'd2;
    localparam logic [2:0] ST_DIGIT3 = 3'd3;
    localparam logic [2:0] ST_OPEN   = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_ONE   = 7'b0000110;
    localparam logic [6:0] GLYPH_TWO   = 7'b1011011;
    localparam logic [6:0] GLYPH_THREE = 7'b1001111;
    localparam logic [6:0] GLYPH_OPEN  = 7'b0111111;
    localparam logic [6:0] GLYPH_ERROR = 7'b1111001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    function automatic logic [6:0] glyph_of(input logic [2:0] code);
        logic [6:0] g;
        case (code)
            ST_IDLE:   g = GLYPH_DASH;
            ST_DIGIT1: g = GLYPH_ONE;
            ST_DIGIT2: g = GLYPH_TWO;
            ST_DIGIT3: g = GLYPH_THREE;
            ST_OPEN:   g = GLYPH_OPEN;
            ST_ERROR:  g = GLYPH_ERROR;
            default:   g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] drive_of(input logic [6:0] glyph);
        logic [6:0] d;
        if (ACTIVE_LOW != 0) begin
            d = ~glyph;
        end else begin
            d = glyph;
        end
        return d;
    endfunction

    localparam logic [6:0] BLANK_DRIVE = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [2:0]       prev_state_q;
    logic [CNT_W-1:0] blink_cnt_q;
    logic [CNT_W-1:0] blink_cnt_d;
    logic             show_q;
    logic             show_d;
    logic [6:0]       seg_q;
    logic [6:0]       seg_d;

    // Next-state for the blink counter/phase and the decoded segment pattern.
    always_comb begin
        blink_cnt_d = '0;
        show_d      = 1'b1;
        seg_d       = drive_of(glyph_of(i_state));
        if (i_state == ST_ERROR) begin
            if (prev_state_q != ST_ERROR) begin
                blink_cnt_d = '0;
                show_d      = 1'b1;
            end else if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                show_d      = ~show_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
                show_d      = show_q;
            end
            // The phase decided at this edge is the one displayed, so entry shows "E" at once.
            if (show_d) begin
                seg_d = drive_of(GLYPH_ERROR);
            end else begin
                seg_d = BLANK_DRIVE;
            end
        end else begin
            blink_cnt_d = '0;
            show_d      = 1'b1;
        end
    end

    // State history, blink counter/phase and output register; reset blanks the display at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_state_q <= ST_IDLE;
            blink_cnt_q  <= '0;
            show_q       <= 1'b1;
            seg_q        <= BLANK_DRIVE;
        end else begin
            prev_state_q <= i_state;
            blink_cnt_q  <= blink_cnt_d;
            show_q       <= show_d;
            seg_q        <= seg_d;
        end
    end

    assign o_7seg = seg_q;

endmodule

// File: tb/tb_safelock_state_decoder.sv
// Directed bench: common-anode decoder with a 3-cycle blink, plus a common-cathode one with a 1-cycle blink.
module tb_safelock_state_decoder;

    logic       clk;
    logic       rst_n;
    logic [2:0] st_a;
    logic [2:0] st_b;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    int         total;
    int         bad;

    safelock_state_decoder #(.ACTIVE_LOW(1), .BLINK_CYCLES(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_state(st_a), .o_7seg(seg_a)
    );

    safelock_state_decoder #(.ACTIVE_LOW(0), .BLINK_CYCLES(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_state(st_b), .o_7seg(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] exp_a;
        logic [6:0] exp_b;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        st_a  = 3'd0;
        st_b  = 3'd4;

        tick(); tick(); tick();
        chk("reset_a", seg_a, 7'h7F);
        chk("reset_b", seg_b, 7'h00);

        rst_n = 1'b1;
        tick();
        chk("first_idle_a", seg_a, 7'b0111111);
        chk("open_b_high", seg_b, 7'b0111111);

        st_a = 3'd1; tick(); chk("sweep1", seg_a, 7'b1111001);
        st_a = 3'd2; tick(); chk("sweep2", seg_a, 7'b0100100);
        st_a = 3'd3; tick(); chk("sweep3", seg_a, 7'b0110000);
        st_a = 3'd4; tick(); chk("sweep4", seg_a, 7'b1000000);
        st_a = 3'd0; tick(); chk("sweep0", seg_a, 7'b0111111);

        st_a = 3'd6; tick(); chk("invalid6", seg_a, 7'b1111111);
        st_a = 3'd7; tick(); chk("invalid7", seg_a, 7'b1111111);

        // Blink: A shows E x3, blank x3, E x3; B toggles every cycle starting with E.
        st_a = 3'd5;
        st_b = 3'd5;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_a = (((i / 3) % 2) == 0) ? 7'b0000110 : 7'b1111111;
            exp_b = ((i % 2) == 0) ? 7'b1111001 : 7'b0000000;
            chk($sformatf("blink_a_%0d", i), seg_a, exp_a);
            chk($sformatf("blink_b_%0d", i), seg_b, exp_b);
        end
        tick(); chk("hide_again_0", seg_a, 7'b1111111);
        tick(); chk("hide_again_1", seg_a, 7'b1111111);

        st_a = 3'd1; tick(); chk("leave_mid_hide", seg_a, 7'b1111001);
        st_a = 3'd5; tick(); chk("reenter_show", seg_a, 7'b0000110);
        tick(); chk("reenter_show_2", seg_a, 7'b0000110);

        st_b = 3'd4;
        st_a = 3'd3; tick();
        chk("state3_before_reset", seg_a, 7'b0110000);
        chk("b_open_again", seg_b, 7'b0111111);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", seg_a, 7'h7F);
        chk("async_reset_b", seg_b, 7'h00);
        tick();
        chk("reset_hold_a", seg_a, 7'h7F);

        st_a  = 3'd5;
        rst_n = 1'b1;
        tick(); chk("post_reset_show", seg_a, 7'b0000110);
        tick(); chk("post_reset_show_2", seg_a, 7'b0000110);
        tick(); chk("post_reset_show_3", seg_a, 7'b0000110);
        tick(); chk("post_reset_hide", seg_a, 7'b1111111);

        st_a = 3'd6; tick(); chk("invalid_after_error", seg_a, 7'b1111111);
        st_a = 3'd5; tick(); chk("error_after_invalid", seg_a, 7'b0000110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
